icache_refill_ctrl: RTL



---
 rtl/icache_pkg.sv | 39 +++
 rtl/refill_rr_arb.sv | 44 ++++
 rtl/icache_refill_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
// Contents: refill FSM state enum, address/data widths, line-address and
// fill-record typedefs, and a helper that splits a word address into tag/idx.
package icache_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned TAG_W       = 22;
    localparam int unsigned WADDR_W     = ADDR_W - 2;
    localparam int unsigned MEM_TIMEOUT = 255;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } refill_state_e;

    // Word address viewed as {tag, idx}; addr[31:10] / addr[9:2].
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } line_addr_t;

    // Everything one subarray needs for a single fill write.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [TAG_W-1:0]  tag;
        logic              way;
        logic [DATA_W-1:0] data;
    } fill_rec_t;

    function automatic line_addr_t to_line(input logic [WADDR_W-1:0] waddr);
        return line_addr_t'(waddr);
    endfunction

endpackage

// File: rtl/refill_rr_arb.sv
// Two-input round-robin arbiter for the refill controller.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req0_i, req1_i      miss requests from subarray 0 / 1
//   upd_i, upd_port_i   pointer update strobe and the port just served
//   win_valid_c_o       combinational: at least one request present
//   win_port_c_o        combinational: winning port id
module refill_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    input  logic upd_port_i,
    output logic win_valid_c_o,
    output logic win_port_c_o
);

    logic rr_q;
    logic rr_d;

    // After a completed fill, priority passes to the port that was not served.
    always_comb begin
        rr_d = rr_q;
        if (upd_i) begin
            rr_d = ~upd_port_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // A lone request wins outright; rr only breaks ties.
    always_comb begin
        win_valid_c_o = req0_i | req1_i;
        win_port_c_o  = (req0_i & req1_i) ? rr_q : req1_i;
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss-refill controller for the dual-subarray instruction cache.
// Arbitrates the two subarray misses onto one memory read port and writes the
// returned word into the requesting subarray at the latched victim way.
// Optional feature macro: ICACHE_REFILL_MERGE_EN (merge simultaneous misses
// to the same word into one read that fills both subarrays).
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   miss{0,1}_i, miss_addr{0,1}_i     per-subarray miss level and PC
//   evict_way{0,1}_i                  per-subarray LRU victim way
//   mem_req_o, mem_addr_o, mem_gnt_i  memory request handshake
//   mem_rvalid_i, mem_rdata_i         memory read return
//   fill_we{0,1}_o, fill_idx/way/tag/data{0,1}_o  subarray fill ports
//   busy_o                            controller not in IDLE
//   timeout_err_o                     sticky memory timeout flag
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              miss0_i,
    input  logic              miss1_i,
    input  logic [ADDR_W-1:0] miss_addr0_i,
    input  logic [ADDR_W-1:0] miss_addr1_i,
    input  logic              evict_way0_i,
    input  logic              evict_way1_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              fill_we0_o,
    output logic [IDX_W-1:0]  fill_idx0_o,
    output logic              fill_way0_o,
    output logic [TAG_W-1:0]  fill_tag0_o,
    output logic [DATA_W-1:0] fill_data0_o,
    output logic              fill_we1_o,
    output logic [IDX_W-1:0]  fill_idx1_o,
    output logic              fill_way1_o,
    output logic [TAG_W-1:0]  fill_tag1_o,
    output logic [DATA_W-1:0] fill_data1_o,
    output logic              busy_o,
    output logic              timeout_err_o
);

    refill_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               port_q, port_d;
    logic               merge_q, merge_d;
    logic [WADDR_W-1:0] waddr_q;
    fill_rec_t          fill0_q, fill1_q;
    logic               mem_req_q;
    logic               busy_q;
    logic               fill_we0_q;
    logic               fill_we1_q;
    logic               timeout_q;

    logic               capture_c;
    logic               data_c;
    logic               timeout_c;
    logic               fill_done_c;
    logic               win_valid_c;
    logic               win_port_c;
    logic               merge_hit_c;
    logic [WADDR_W-1:0] win_waddr_c;
    line_addr_t         win_line_c;

    // Byte offset of the PC is irrelevant to a word refill.
    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^{miss_addr0_i[1:0], miss_addr1_i[1:0]};

    // Pointer advances only on a single-port fill; merged fills leave it alone.
    refill_rr_arb u_arb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0_i        (miss0_i),
        .req1_i        (miss1_i),
        .upd_i         (fill_done_c & ~merge_q),
        .upd_port_i    (port_q),
        .win_valid_c_o (win_valid_c),
        .win_port_c_o  (win_port_c)
    );

`ifdef ICACHE_REFILL_MERGE_EN
    assign merge_hit_c = miss0_i & miss1_i &
                         (miss_addr0_i[ADDR_W-1:2] == miss_addr1_i[ADDR_W-1:2]);
`else
    assign merge_hit_c = 1'b0;
`endif

    assign win_waddr_c = win_port_c ? miss_addr1_i[ADDR_W-1:2] : miss_addr0_i[ADDR_W-1:2];
    assign win_line_c  = to_line(win_waddr_c);

    // Next-state and control strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        merge_d     = merge_q;
        capture_c   = 1'b0;
        data_c      = 1'b0;
        timeout_c   = 1'b0;
        fill_done_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    capture_c = 1'b1;
                    port_d    = win_port_c;
                    merge_d   = merge_hit_c;
                    state_d   = REQ;
                end
            end
            REQ: begin
                cnt_d = '0;
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid_i) begin
                    data_c  = 1'b1;
                    state_d = FILL;
                end else if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
                    // Abandon the read; the still-held miss is re-arbitrated.
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            FILL: begin
                fill_done_c = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            port_q     <= 1'b0;
            merge_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            fill_we0_q <= 1'b0;
            fill_we1_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            merge_q    <= merge_d;
            mem_req_q  <= (state_d == REQ);
            busy_q     <= (state_d != IDLE);
            fill_we0_q <= (state_d == FILL) & (merge_d | ~port_d);
            fill_we1_q <= (state_d == FILL) & (merge_d | port_d);
            timeout_q  <= timeout_q | timeout_c;
        end
    end

    // Address, tag/idx and both victim ways are frozen when IDLE is left.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waddr_q <= '0;
            fill0_q <= '0;
            fill1_q <= '0;
        end else begin
            if (capture_c) begin
                waddr_q     <= win_waddr_c;
                fill0_q.idx <= win_line_c.idx;
                fill0_q.tag <= win_line_c.tag;
                fill0_q.way <= evict_way0_i;
                fill1_q.idx <= win_line_c.idx;
                fill1_q.tag <= win_line_c.tag;
                fill1_q.way <= evict_way1_i;
            end
            if (data_c) begin
                fill0_q.data <= mem_rdata_i;
                fill1_q.data <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = {waddr_q, 2'b00};
    assign busy_o        = busy_q;
    assign timeout_err_o = timeout_q;

    assign fill_we0_o    = fill_we0_q;
    assign fill_idx0_o   = fill0_q.idx;
    assign fill_way0_o   = fill0_q.way;
    assign fill_tag0_o   = fill0_q.tag;
    assign fill_data0_o  = fill0_q.data;

    assign fill_we1_o    = fill_we1_q;
    assign fill_idx1_o   = fill1_q.idx;
    assign fill_way1_o   = fill1_q.way;
    assign fill_tag1_o   = fill1_q.tag;
    assign fill_data1_o  = fill1_q.data;

endmodule
